// File: rtl/sprite_regs_pkg.sv
// sprite_regs_pkg
//   Shared constants for the sprite/score register shadow block:
//   register indices of the Avalon map, bank geometry, power-on values
//   of the sprite/score registers and the CTRL register bit positions.
//   Imported by sprite_reg_shadow and available to any software-facing
//   model that needs the same map.

package sprite_regs_pkg;

  // Bank geometry
  localparam int SPR_NREGS = 13;
  localparam int SPR_DW    = 8;

  // Sprite/score register indices (Avalon word addresses)
  localparam int REG_DINO_X   = 0;
  localparam int REG_DINO_Y   = 1;
  localparam int REG_CACTUS_X = 2;
  localparam int REG_CACTUS_Y = 3;
  localparam int REG_BIRD_X   = 4;
  localparam int REG_BIRD_Y   = 5;
  localparam int REG_CLOUD_X  = 6;
  localparam int REG_CLOUD_Y  = 7;
  localparam int REG_GROUND_X = 8;
  localparam int REG_SPEED    = 9;
  localparam int REG_SCORE    = 10;
  localparam int REG_SCORE_X  = 11;
  localparam int REG_SCORE_Y  = 12;

  // Control/status registers following the sprite bank
  localparam int REG_CTRL    = 13;
  localparam int REG_FRAME   = 14;
  localparam int REG_IRQ_ACK = 15;

  // CTRL register bit positions
  localparam int CTRL_PENDING_BIT = 0;
  localparam int CTRL_AUTO_BIT    = 1;
  localparam int CTRL_IRQ_BIT     = 2;

  // Power-on contents of both banks, registers 0..12
  localparam logic [SPR_DW-1:0] RESET_VALS [SPR_NREGS] = '{
    8'd100, 8'd100, 8'd200, 8'd150, 8'd44, 8'd200, 8'd244,
    8'd100, 8'd100, 8'd4,   8'd0,   8'd0,   8'd0
  };

  localparam int RV_AW = $clog2(SPR_NREGS);

  // Power-on value for register k; registers beyond the table start at 0.
  function automatic logic [SPR_DW-1:0] reset_val(input int k);
    logic [SPR_DW-1:0] v;
    v = '0;
    if (k >= 0 && k < SPR_NREGS) begin
      v = RESET_VALS[RV_AW'(k)];
    end
    return v;
  endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// vsync_edge_detect
//   Registers the active-low VGA vertical sync and flags the cycle in
//   which it falls (start of the sync pulse).
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   vga_vs   in   VGA_VS from the timing counters (active-low)
//   vs_fall  out  high for the one cycle where vs_q == 1 and vga_vs == 0

module vsync_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic vga_vs,
  output logic vs_fall
);

  logic vs_q;

  // vs_q resets high so a sync line that is already low when reset is
  // released does not count as a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= vga_vs;
    end
  end

  // Combinational on purpose: the commit must land on the same clock edge
  // that samples the falling sync, not one cycle later.
  assign vs_fall = vs_q & ~vga_vs;

endmodule

// File: rtl/sprite_reg_shadow.sv
// sprite_reg_shadow
//   Double-buffered sprite/score register file between the Avalon bus and
//   the display stage. The CPU writes a shadow bank at any time; the shadow
//   is copied to the active bank only at the start of vertical sync so
//   sprites never tear mid-frame. Also keeps a frame counter and a CTRL
//   register (pending / auto commit) for software frame pacing.
//
// Build option:
//   FRAME_IRQ_EN  when defined, a frame interrupt status bit is set on
//                 every commit, cleared by writing 1 to IRQ_ACK, and drives
//                 irq. When undefined, irq is tied 0, CTRL bit2 reads 0 and
//                 address 15 is unmapped.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   chipselect/write/read Avalon slave strobes (no waitrequest)
//   address[8:0]          word address
//   writedata[31:0]       write data, registers use bits [DW-1:0]
//   readdata[31:0]        registered read data, 1-cycle latency
//   vga_vs                VGA vertical sync, active-low
//   active_regs           active bank, register k at [k*DW +: DW]
//   commit_pulse          one cycle high when the active bank is reloaded
//   frame_count[FCW-1:0]  vsync counter, wraps
//   irq                   frame interrupt (0 unless FRAME_IRQ_EN)

module sprite_reg_shadow
  import sprite_regs_pkg::*;
#(
  parameter int NREGS = SPR_NREGS,
  parameter int DW    = SPR_DW,
  parameter int FCW   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [8:0]          address,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic                vga_vs,
  output logic [NREGS*DW-1:0] active_regs,
  output logic                commit_pulse,
  output logic [FCW-1:0]      frame_count,
  output logic                irq
);

  // ------------------------------------------------------------------
  // Bus decode
  // ------------------------------------------------------------------
  logic wr_en;
  logic rd_en;
  logic ctrl_wr;

  assign wr_en   = chipselect & write;
  assign rd_en   = chipselect & read;
  assign ctrl_wr = wr_en && (address == 9'(REG_CTRL));

  // Only the low DW bits of writedata carry register data.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:DW];

  // ------------------------------------------------------------------
  // Frame start detection and commit decision
  // ------------------------------------------------------------------
  logic vs_fall;

  vsync_edge_detect u_vs_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .vga_vs  (vga_vs),
    .vs_fall (vs_fall)
  );

  logic [NREGS-1:0] dirty;
  logic             pending_reg;
  logic             auto_reg;
  logic             irq_stat;
  logic             commit;

  assign commit = vs_fall && (pending_reg || (auto_reg && (|dirty)));

  // ------------------------------------------------------------------
  // Register banks: one shadow, one active and one dirty bit per register
  // ------------------------------------------------------------------
  logic [NREGS*DW-1:0] shadow_masked;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam logic [DW-1:0] RST_VAL = DW'(reset_val(gi));

      logic [DW-1:0] shadow_reg;
      logic [DW-1:0] active_reg;
      logic          dirty_reg;
      logic          hit;

      assign hit = (address == 9'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          shadow_reg <= RST_VAL;
          active_reg <= RST_VAL;
          dirty_reg  <= 1'b0;
        end else begin
          // The active bank takes the pre-write shadow value when a CPU
          // write and a commit share the same cycle.
          if (commit) begin
            active_reg <= shadow_reg;
          end
          // A write in the commit cycle keeps the register dirty so the
          // new value goes out on the following frame.
          if (wr_en && hit) begin
            shadow_reg <= writedata[DW-1:0];
            dirty_reg  <= 1'b1;
          end else if (commit) begin
            dirty_reg <= 1'b0;
          end
        end
      end

      assign active_regs[gi*DW +: DW]   = active_reg;
      assign dirty[gi]                  = dirty_reg;
      assign shadow_masked[gi*DW +: DW] = hit ? shadow_reg : '0;
    end
  endgenerate

  // Address decode is one-hot over the bank, so the read value is the
  // per-bit OR of the masked shadow registers.
  logic [DW-1:0] shadow_sel;

  generate
    for (genvar gb = 0; gb < DW; gb++) begin : g_rd_bit
      logic [NREGS-1:0] column;
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_col
        assign column[gi] = shadow_masked[gi*DW + gb];
      end
      assign shadow_sel[gb] = |column;
    end
  endgenerate

  // ------------------------------------------------------------------
  // CTRL: pending (self-clearing on commit) and auto commit enable
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg <= 1'b0;
      auto_reg    <= 1'b0;
    end else begin
      // Setting pending in the commit cycle wins, so the request carries
      // over to the next frame instead of being lost.
      if (ctrl_wr && writedata[CTRL_PENDING_BIT]) begin
        pending_reg <= 1'b1;
      end else if (commit) begin
        pending_reg <= 1'b0;
      end
      if (ctrl_wr) begin
        auto_reg <= writedata[CTRL_AUTO_BIT];
      end
    end
  end

  // ------------------------------------------------------------------
  // Frame counter and commit pulse
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count  <= '0;
      commit_pulse <= 1'b0;
    end else begin
      if (vs_fall) begin
        frame_count <= frame_count + 1'b1;
      end
      commit_pulse <= commit;
    end
  end

  // ------------------------------------------------------------------
  // Frame interrupt
  // ------------------------------------------------------------------
`ifdef FRAME_IRQ_EN
  logic irq_stat_reg;
  logic ack_wr;

  assign ack_wr = wr_en && (address == 9'(REG_IRQ_ACK)) && writedata[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_stat_reg <= 1'b0;
    end else if (commit) begin
      // Set wins over a simultaneous acknowledge.
      irq_stat_reg <= 1'b1;
    end else if (ack_wr) begin
      irq_stat_reg <= 1'b0;
    end
  end

  assign irq_stat = irq_stat_reg;
`else
  assign irq_stat = 1'b0;
`endif

  assign irq = irq_stat;

  // ------------------------------------------------------------------
  // Read path, registered
  // ------------------------------------------------------------------
  logic [31:0] ctrl_word;
  logic [31:0] rd_next;

  always_comb begin
    ctrl_word                   = '0;
    ctrl_word[CTRL_PENDING_BIT] = pending_reg;
    ctrl_word[CTRL_AUTO_BIT]    = auto_reg;
    ctrl_word[CTRL_IRQ_BIT]     = irq_stat;
  end

  always_comb begin
    rd_next = '0;
    if (address < 9'(NREGS)) begin
      rd_next = 32'(shadow_sel);
    end else if (address == 9'(REG_CTRL)) begin
      rd_next = ctrl_word;
    end else if (address == 9'(REG_FRAME)) begin
      rd_next = 32'(frame_count);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_sprite_reg_shadow.sv
// tb_sprite_reg_shadow
//   Directed scenarios plus a randomized run against a transaction-level
//   model of the register map (arrays for the two banks, flags for CTRL).
//   The DUT is built with a narrow frame counter so the wrap is reachable
//   in a short run. Works with and without FRAME_IRQ_EN.

module tb_sprite_reg_shadow;

  localparam int NR     = 13;
  localparam int DWD    = 8;
  localparam int TB_FCW = 8;
`ifdef FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              chipselect = 1'b0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic [8:0]        address = '0;
  logic [31:0]       writedata = '0;
  logic              vga_vs = 1'b1;
  logic [31:0]       readdata;
  logic [NR*DWD-1:0] active_regs;
  logic              commit_pulse;
  logic [TB_FCW-1:0] frame_count;
  logic              irq;

  sprite_reg_shadow #(.NREGS(NR), .DW(DWD), .FCW(TB_FCW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .chipselect   (chipselect),
    .write        (write),
    .read         (read),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .vga_vs       (vga_vs),
    .active_regs  (active_regs),
    .commit_pulse (commit_pulse),
    .frame_count  (frame_count),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [7:0] def_m [NR] = '{8'd100, 8'd100, 8'd200, 8'd150, 8'd44, 8'd200, 8'd244,
                             8'd100, 8'd100, 8'd4, 8'd0, 8'd0, 8'd0};
  logic [7:0]        shadow_m [NR];
  logic [7:0]        active_m [NR];
  bit                dirty_m  [NR];
  bit                pending_m, auto_m, irq_m, prev_vs_m, exp_pulse;
  logic [TB_FCW-1:0] fc_m;
  logic [31:0]       exp_rd;

  function automatic logic [NR*DWD-1:0] pack_active();
    logic [NR*DWD-1:0] p;
    for (int k = 0; k < NR; k++) p[k*DWD +: DWD] = active_m[k];
    return p;
  endfunction

  function automatic logic [NR*DWD-1:0] pack_defaults();
    logic [NR*DWD-1:0] p;
    for (int k = 0; k < NR; k++) p[k*DWD +: DWD] = def_m[k];
    return p;
  endfunction

  function automatic logic [31:0] model_read(input logic [8:0] a);
    if (a < 9'd13) return {24'd0, shadow_m[a]};
    if (a == 9'd13) return {29'd0, irq_m, auto_m, pending_m};
    if (a == 9'd14) return 32'(fc_m);
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) begin
      shadow_m[k] = def_m[k];
      active_m[k] = def_m[k];
      dirty_m[k]  = 1'b0;
    end
    pending_m = 0; auto_m = 0; irq_m = 0; prev_vs_m = 1; exp_pulse = 0;
    fc_m = '0; exp_rd = '0;
  endtask

  // One clock cycle of bus/vsync activity as the specification describes it.
  task automatic model_step(input bit c, input bit w, input bit r, input logic [8:0] a,
                            input logic [31:0] d, input bit v);
    bit edge_ev, any_dirty, cmt;
    if (c && r) exp_rd = model_read(a);
    edge_ev = prev_vs_m && !v;
    any_dirty = 0;
    for (int k = 0; k < NR; k++) any_dirty |= dirty_m[k];
    cmt = edge_ev && (pending_m || (auto_m && any_dirty));
    if (edge_ev) fc_m = fc_m + 1'b1;
    if (cmt) begin
      for (int k = 0; k < NR; k++) begin
        active_m[k] = shadow_m[k];
        dirty_m[k]  = 1'b0;
      end
      pending_m = 0;
      if (IRQ_EN) irq_m = 1;
    end
    exp_pulse = cmt;
    if (c && w) begin
      if (a < 9'd13) begin
        shadow_m[a] = d[7:0];
        dirty_m[a]  = 1'b1;
      end else if (a == 9'd13) begin
        if (d[0]) pending_m = 1;
        auto_m = d[1];
      end else if (a == 9'd15 && IRQ_EN && d[0] && !cmt) begin
        irq_m = 0;
      end
    end
    prev_vs_m = v;
  endtask

  // Drive one cycle, advance the model at the edge, sample 1 ns later.
  task automatic tick(input bit c, input bit w, input bit r, input logic [8:0] a,
                      input logic [31:0] d, input bit v);
    chipselect = c; write = w; read = r; address = a; writedata = d; vga_vs = v;
    @(posedge clk);
    model_step(c, w, r, a, d, v);
    #1;
    chipselect = 0; write = 0; read = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 0; vga_vs = 1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1;
    model_reset();
    n_checks++; if (active_regs !== pack_defaults()) $display("FAIL reset_active: got %h expected %h", active_regs, pack_defaults()); else n_pass++;
    n_checks++; if (frame_count !== '0) $display("FAIL reset_frame: got %0d expected 0", frame_count); else n_pass++;
    n_checks++; if (commit_pulse !== 1'b0) $display("FAIL reset_pulse: got %b expected 0", commit_pulse); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else n_pass++;
    n_checks++; if (readdata !== 32'd0) $display("FAIL reset_readdata: got %0h expected 0", readdata); else n_pass++;
    for (int k = 0; k < NR; k++) begin
      tick(1, 0, 1, 9'(k), 32'd0, 1);
      n_checks++;
      if (readdata !== {24'd0, def_m[k]}) $display("FAIL reset_read_reg%0d: got %0d expected %0d", k, readdata, def_m[k]);
      else n_pass++;
    end
  endtask

  task automatic test_hold_without_commit();
    bit saw_pulse = 0;
    tick(1, 1, 0, 9'd0, 32'd55, 1);
    tick(0, 0, 0, 9'd0, 32'd0, 0);   // vsync falls
    saw_pulse |= commit_pulse;
    n_checks++; if (active_regs[7:0] !== 8'd100) $display("FAIL hold_active0: got %0d expected 100", active_regs[7:0]); else n_pass++;
    n_checks++; if (frame_count !== 8'd1) $display("FAIL hold_frame: got %0d expected 1", frame_count); else n_pass++;
    tick(0, 0, 0, 9'd0, 32'd0, 0);
    saw_pulse |= commit_pulse;
    tick(0, 0, 0, 9'd0, 32'd0, 1);
    saw_pulse |= commit_pulse;
    n_checks++; if (saw_pulse !== 1'b0) $display("FAIL hold_no_pulse: got %b expected 0", saw_pulse); else n_pass++;
  endtask

  task automatic test_pending_commit();
    tick(1, 1, 0, 9'd13, 32'd1, 1);  // CTRL.pending = 1
    tick(0, 0, 0, 9'd0, 32'd0, 0);   // commit edge
    n_checks++; if (active_regs[7:0] !== 8'd55) $display("FAIL pend_active0: got %0d expected 55", active_regs[7:0]); else n_pass++;
    n_checks++; if (commit_pulse !== 1'b1) $display("FAIL pend_pulse: got %b expected 1", commit_pulse); else n_pass++;
    n_checks++; if (frame_count !== 8'd2) $display("FAIL pend_frame: got %0d expected 2", frame_count); else n_pass++;
    tick(0, 0, 0, 9'd0, 32'd0, 0);
    n_checks++; if (commit_pulse !== 1'b0) $display("FAIL pend_pulse_width: got %b expected 0", commit_pulse); else n_pass++;
    tick(0, 0, 0, 9'd0, 32'd0, 1);
    tick(1, 0, 1, 9'd13, 32'd0, 1);
    n_checks++; if (readdata !== (IRQ_EN ? 32'd4 : 32'd0)) $display("FAIL pend_ctrl_read: got %0h expected %0h", readdata, (IRQ_EN ? 32'd4 : 32'd0)); else n_pass++;
  endtask

  task automatic test_commit_collision();
    tick(1, 1, 0, 9'd13, 32'd2, 1);  // auto = 1
    tick(1, 1, 0, 9'd10, 32'd9, 1);  // reg10 dirty with 9
    tick(1, 1, 0, 9'd10, 32'd7, 0);  // write 7 in the commit cycle
    n_checks++; if (commit_pulse !== 1'b1) $display("FAIL coll_pulse: got %b expected 1", commit_pulse); else n_pass++;
    n_checks++; if (active_regs[87:80] !== 8'd9) $display("FAIL coll_active10: got %0d expected 9", active_regs[87:80]); else n_pass++;
    tick(1, 0, 1, 9'd10, 32'd0, 0);
    n_checks++; if (readdata !== 32'd7) $display("FAIL coll_shadow10: got %0d expected 7", readdata); else n_pass++;
    tick(0, 0, 0, 9'd0, 32'd0, 1);
    tick(1, 1, 0, 9'd13, 32'd3, 0);  // pending set in the commit cycle
    n_checks++; if (active_regs[87:80] !== 8'd7) $display("FAIL coll_next_active10: got %0d expected 7", active_regs[87:80]); else n_pass++;
    n_checks++; if (commit_pulse !== 1'b1) $display("FAIL coll_next_pulse: got %b expected 1", commit_pulse); else n_pass++;
    tick(1, 0, 1, 9'd13, 32'd0, 1);
    n_checks++; if (readdata !== (IRQ_EN ? 32'd7 : 32'd3)) $display("FAIL coll_ctrl_pending: got %0h expected %0h", readdata, (IRQ_EN ? 32'd7 : 32'd3)); else n_pass++;
    tick(0, 0, 0, 9'd0, 32'd0, 0);   // carried-over pending commits
    n_checks++; if (commit_pulse !== 1'b1) $display("FAIL coll_carry_pulse: got %b expected 1", commit_pulse); else n_pass++;
    tick(0, 0, 0, 9'd0, 32'd0, 1);
  endtask

  task automatic test_irq();
    n_checks++; if (irq !== IRQ_EN) $display("FAIL irq_after_commit: got %b expected %b", irq, IRQ_EN); else n_pass++;
    tick(1, 1, 0, 9'd15, 32'd1, 1);
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_ack: got %b expected 0", irq); else n_pass++;
    tick(1, 1, 0, 9'd3, 32'd1, 1);   // dirty, auto is on
    tick(1, 1, 0, 9'd15, 32'd1, 0);  // ack in the commit cycle
    n_checks++; if (commit_pulse !== 1'b1) $display("FAIL irq_coll_pulse: got %b expected 1", commit_pulse); else n_pass++;
    n_checks++; if (irq !== IRQ_EN) $display("FAIL irq_set_wins: got %b expected %b", irq, IRQ_EN); else n_pass++;
    tick(1, 1, 0, 9'd15, 32'd1, 1);
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_ack2: got %b expected 0", irq); else n_pass++;
    tick(1, 0, 1, 9'd13, 32'd0, 1);
    n_checks++; if (readdata !== 32'd2) $display("FAIL irq_ctrl_read: got %0h expected 2", readdata); else n_pass++;
  endtask

  task automatic test_frame_wrap();
    int guard = 0;
    while (fc_m != '1 && guard < 600) begin
      tick(0, 0, 0, 9'd0, 32'd0, 0);
      tick(0, 0, 0, 9'd0, 32'd0, 1);
      guard++;
    end
    n_checks++; if (frame_count !== 8'hFF) $display("FAIL wrap_at_max: got %0h expected ff", frame_count); else n_pass++;
    tick(0, 0, 0, 9'd0, 32'd0, 0);
    n_checks++; if (frame_count !== 8'h00) $display("FAIL wrap_to_zero: got %0h expected 0", frame_count); else n_pass++;
    tick(1, 0, 1, 9'd14, 32'd0, 1);
    n_checks++; if (readdata !== 32'd0) $display("FAIL wrap_frame_read: got %0h expected 0", readdata); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bit c, w, r, v;
      int op;
      logic [8:0] a;
      logic [31:0] d;
      c  = ($urandom_range(0, 7) != 0);
      op = $urandom_range(0, 2);
      w  = (op == 0);
      r  = (op == 1);
      a  = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(16, 511)) : 9'($urandom_range(0, 15));
      d  = $urandom;
      v  = ($urandom_range(0, 5) != 0);
      tick(c, w, r, a, d, v);
      n_checks++; if (readdata !== exp_rd) $display("FAIL rnd_readdata[%0d]: got %0h expected %0h", i, readdata, exp_rd); else n_pass++;
      n_checks++; if (active_regs !== pack_active()) $display("FAIL rnd_active[%0d]: got %h expected %h", i, active_regs, pack_active()); else n_pass++;
      n_checks++; if (commit_pulse !== exp_pulse) $display("FAIL rnd_pulse[%0d]: got %b expected %b", i, commit_pulse, exp_pulse); else n_pass++;
      n_checks++; if (frame_count !== fc_m) $display("FAIL rnd_frame[%0d]: got %0d expected %0d", i, frame_count, fc_m); else n_pass++;
      n_checks++; if (irq !== irq_m) $display("FAIL rnd_irq[%0d]: got %b expected %b", i, irq, irq_m); else n_pass++;
    end
    tick(0, 0, 0, 9'd0, 32'd0, 1);
  endtask

  task automatic test_async_reset();
    tick(1, 1, 0, 9'd0, 32'd77, 1);
    tick(1, 1, 0, 9'd13, 32'd1, 1);
    tick(1, 0, 1, 9'd0, 32'd0, 1);
    tick(0, 0, 0, 9'd0, 32'd0, 0);   // commit
    n_checks++; if (commit_pulse !== 1'b1) $display("FAIL arst_pre_pulse: got %b expected 1", commit_pulse); else n_pass++;
    n_checks++; if (readdata !== 32'd77) $display("FAIL arst_pre_read: got %0d expected 77", readdata); else n_pass++;
    #2 reset_n = 0;                  // mid-cycle, no clock edge
    model_reset();
    #1;
    n_checks++; if (active_regs !== pack_defaults()) $display("FAIL arst_active: got %h expected %h", active_regs, pack_defaults()); else n_pass++;
    n_checks++; if (frame_count !== '0) $display("FAIL arst_frame: got %0d expected 0", frame_count); else n_pass++;
    n_checks++; if (commit_pulse !== 1'b0) $display("FAIL arst_pulse: got %b expected 0", commit_pulse); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL arst_irq: got %b expected 0", irq); else n_pass++;
    n_checks++; if (readdata !== 32'd0) $display("FAIL arst_readdata: got %0h expected 0", readdata); else n_pass++;
    vga_vs = 1;
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    tick(1, 0, 1, 9'd0, 32'd0, 1);
    n_checks++; if (readdata !== 32'd100) $display("FAIL arst_shadow0: got %0d expected 100", readdata); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_hold_without_commit();
    test_pending_commit();
    test_commit_collision();
    test_irq();
    test_frame_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
